clk_div_ctrl: RTL and testbench

Runtime controller for the shared clock-division resource in the SDRAM subsystem. From `i_clk` it generates a programmable clock-enable strobe (`o_clk_en`) and a divided-clock level (`o_clk_div`). It accepts divide-ratio changes over a valid/ready handshake and applies each change only at a period boundary, so no runt pulses are produced. After every start or ratio change it reports stability on `o_locked` once a settle window has elapsed.

---
 rtl/clk_div_ctrl_pkg.sv | 9 +
 rtl/clk_div_ctrl_if.sv | 16 +
 rtl/clk_div_core.sv | 24 ++
 rtl/clk_div_ctrl.sv | 82 ++++++++
 tb/tb_clk_div_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared types and helpers for the clock-division controller
// Contents: FSM state enum, default divide-ratio width, half_ceil() for the high-phase length
package clk_ctrl_pkg;
  localparam int DIV_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, SWITCH} state_t;
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) / 2;
  endfunction
endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: run request, ratio handshake and divider outputs of the clock-division controller
// master drives en/cfg_valid/cfg_div; slave (controller) drives cfg_ready/clk_en/clk_div/locked/err
interface clk_div_ctrl_if import clk_ctrl_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
);
  logic en;
  logic cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic cfg_ready;
  logic clk_en;
  logic clk_div;
  logic locked;
  logic err;
  modport master (output en, cfg_valid, cfg_div, input cfg_ready, clk_en, clk_div, locked, err);
  modport slave (input en, cfg_valid, cfg_div, output cfg_ready, clk_en, clk_div, locked, err);
endinterface

// File: rtl/clk_div_core.sv
// clk_div_core: period counter that decodes the enable strobe and divided-clock level for ratio n
// clk/rst: clock and sync reset; run: count enable (held at 0 otherwise); load: restart period
// n: divide ratio; clk_en: strobe on the last cycle of a period; clk_div: high for ceil(n/2) cycles
module clk_div_core import clk_ctrl_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] n,
  output logic             clk_en,
  output logic             clk_div
);
  logic [DIV_W-1:0] cnt;
  logic last;
  assign last = cnt == n - DIV_W'(1);
  assign clk_en = run & last;
  assign clk_div = run & (cnt < DIV_W'(half_ceil(32'(n))));
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= (!run || load || last) ? '0 : cnt + DIV_W'(1);
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime clock-division controller with boundary-aligned ratio changes and lock report
// clk/rst: clock and sync active-high reset; bus: slave side of clk_div_ctrl_if
// Ratio changes are held in pend_q and applied only on the last cycle of the current period.
module clk_div_ctrl import clk_ctrl_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV_RST = 2,
  parameter int LOCK_CYC = 16
) (
  input logic clk,
  input logic rst,
  clk_div_ctrl_if.slave bus
);
  localparam int LW = $clog2(LOCK_CYC + 1);
  state_t state, state_n;
  logic [DIV_W-1:0] div_q, div_n, pend_q, pend_n;
  logic [LW-1:0] lock_cnt, lock_n;
  logic live_q, err_q, run, load, tick, acc, zero;
  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .clk(clk),
    .rst(rst),
    .run(run),
    .load(load),
    .n(div_q),
    .clk_en(tick),
    .clk_div(bus.clk_div)
  );
  assign run = state != IDLE;
  assign load = state == SWITCH && tick;
  assign acc = bus.cfg_valid && bus.cfg_ready;
  assign zero = bus.cfg_div == '0;
  assign bus.clk_en = tick;
  assign bus.cfg_ready = live_q && state != SWITCH;
  assign bus.locked = state == RUN;
  assign bus.err = err_q;
  always_comb begin
    state_n = state;
    div_n = div_q;
    pend_n = pend_q;
    lock_n = lock_cnt;
    case (state)
      IDLE: begin
        if (acc && !zero) div_n = bus.cfg_div;
        if (bus.en) begin
          state_n = SETTLE;
          lock_n = '0;
        end
      end
      SETTLE, RUN: begin
        if (state == SETTLE) lock_n = lock_cnt + LW'(1);
        if (acc && !zero) begin
          pend_n = bus.cfg_div;
          state_n = SWITCH;
        end
        else if (tick && !bus.en) state_n = IDLE;
        else if (state == SETTLE && lock_cnt == LW'(LOCK_CYC - 1)) state_n = RUN;
      end
      SWITCH: if (tick) begin
        div_n = pend_q;
        lock_n = '0;
        state_n = bus.en ? SETTLE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_q <= DIV_W'(DIV_RST);
      pend_q <= '0;
      lock_cnt <= '0;
      live_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      div_q <= div_n;
      pend_q <= pend_n;
      lock_cnt <= lock_n;
      live_q <= 1'b1;
      err_q <= acc && zero;
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed scoreboard bench for clk_div_ctrl (DIV_RST=2, LOCK_CYC=16)
module tb_clk_div_ctrl;
  typedef struct packed {
    logic ce;
    logic cd;
    logic lk;
    logic rdy;
    logic er;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  clk_div_ctrl_if #(.DIV_W(8)) bus ();
  clk_div_ctrl #(.DIV_W(8), .DIV_RST(2), .LOCK_CYC(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic obs, logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp_v);
    end
  endtask
  task automatic push_run(int n, int cnt, int ph, int lock_at, bit rdy, bit er1);
    for (int i = 0; i < cnt; i++) begin
      int p = (ph + i) % n;
      q.push_back('{ce: p == n - 1, cd: p < (n + 1) / 2, lk: i >= lock_at, rdy: rdy, er: er1 && i == 0});
    end
  endtask
  task automatic push_idle(int cnt, bit rdy);
    for (int i = 0; i < cnt; i++) q.push_back('{ce: 1'b0, cd: 1'b0, lk: 1'b0, rdy: rdy, er: 1'b0});
  endtask
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard cycle %0d observed empty queue expected an entry", cyc);
    end
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("clk_en", bus.clk_en, e.ce);
    chk("clk_div", bus.clk_div, e.cd);
    chk("locked", bus.locked, e.lk);
    chk("cfg_ready", bus.cfg_ready, e.rdy);
    chk("err", bus.err, e.er);
  endtask
  task automatic run_n(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    bus.en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div = '0;
    push_idle(2, 1'b0);
    run_n(2);
    rst = 1'b0;
    push_idle(1, 1'b1);
    step();
    bus.en = 1'b1;
    push_run(2, 25, 0, 16, 1'b1, 1'b0);
    run_n(25);
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd5;
    push_run(2, 1, 1, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b0;
    push_run(5, 25, 0, 16, 1'b1, 1'b0);
    run_n(25);
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd0;
    push_run(5, 1, 0, 0, 1'b1, 1'b1);
    step();
    bus.cfg_valid = 1'b0;
    push_run(5, 10, 1, 0, 1'b1, 1'b0);
    run_n(10);
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd1;
    push_run(5, 4, 1, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b0;
    run_n(3);
    push_run(1, 20, 0, 16, 1'b1, 1'b0);
    run_n(20);
    bus.en = 1'b0;
    push_idle(3, 1'b1);
    run_n(3);
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd4;
    push_idle(1, 1'b1);
    step();
    bus.cfg_valid = 1'b0;
    bus.en = 1'b1;
    push_run(4, 21, 0, 16, 1'b1, 1'b0);
    run_n(21);
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd7;
    push_run(4, 1, 1, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b0;
    bus.en = 1'b0;
    push_run(4, 1, 2, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd3;
    push_run(4, 1, 3, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b0;
    push_idle(3, 1'b1);
    run_n(3);
    bus.en = 1'b1;
    push_run(7, 21, 0, 16, 1'b1, 1'b0);
    run_n(21);
    push_run(7, 1, 0, 0, 1'b1, 1'b0);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div = 8'd3;
    push_run(7, 1, 1, 1000, 1'b0, 1'b0);
    step();
    bus.cfg_valid = 1'b0;
    bus.en = 1'b0;
    rst = 1'b1;
    push_idle(2, 1'b0);
    run_n(2);
    rst = 1'b0;
    push_idle(1, 1'b1);
    step();
    bus.en = 1'b1;
    push_run(2, 6, 0, 16, 1'b1, 1'b0);
    run_n(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
